// File: rtl/morty_pipe_pkg.sv
// Shared occupancy encodings and default widths for the pipeline stage buffer family.
package morty_pipe_pkg;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_EXC_W  = 11;
   localparam int DEFAULT_CNT_W  = 16;

endpackage

// File: rtl/morty_sat_counter.sv
// Up-counter that sticks at its maximum value instead of wrapping.
module morty_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (en_i && (r_cnt != {WIDTH{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: a registered main entry plus an optional skid entry,
// with flush, stall hold and a saturating count of blocked output cycles.
module pipe_stage_buf
   import morty_pipe_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int EXC_W  = DEFAULT_EXC_W,
   parameter int SKID   = 1,
   parameter int CNT_W  = DEFAULT_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              stall_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic [EXC_W-1:0]  in_exc_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [EXC_W-1:0]  out_exc_o,
   output logic [1:0]        occ_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   logic [DATA_W-1:0] r_mainData;
   logic [EXC_W-1:0]  r_mainExc;
   logic              r_outValid;
   logic [1:0]        r_occ;
   logic              w_accept;
   logic              w_consume;
   logic              w_stallEn;

   assign w_accept  = in_valid_i & in_ready_o & ~clear_i;
   assign w_consume = r_outValid & out_ready_i & ~stall_i;

   generate
      if (SKID != 0) begin : g_skid
         logic [DATA_W-1:0] r_skidData;
         logic [EXC_W-1:0]  r_skidExc;
         logic              r_inReady;
         logic [1:0]        w_occNext;

         always_comb begin
            w_occNext = r_occ;
            case (r_occ)
               OCC_EMPTY: if (w_accept) w_occNext = OCC_ONE;
               OCC_ONE: begin
                  if (w_accept && !w_consume) w_occNext = OCC_FULL;
                  else if (!w_accept && w_consume) w_occNext = OCC_EMPTY;
               end
               OCC_FULL:  if (w_consume) w_occNext = OCC_ONE;
               default:   w_occNext = OCC_EMPTY;
            endcase
         end

         // Flush and reset share one path; ready is precomputed so it never depends on downstream.
         always_ff @(posedge clk) begin
            if (rst || clear_i) begin
               r_mainData <= '0;
               r_mainExc  <= '0;
               r_skidData <= '0;
               r_skidExc  <= '0;
               r_outValid <= 1'b0;
               r_occ      <= OCC_EMPTY;
               r_inReady  <= 1'b1;
            end else begin
               r_occ      <= w_occNext;
               r_outValid <= (w_occNext != OCC_EMPTY);
               r_inReady  <= (w_occNext != OCC_FULL);
               case (r_occ)
                  OCC_EMPTY: begin
                     if (w_accept) begin
                        r_mainData <= in_data_i;
                        r_mainExc  <= in_exc_i;
                     end
                  end
                  OCC_ONE: begin
                     if (w_accept && w_consume) begin
                        r_mainData <= in_data_i;
                        r_mainExc  <= in_exc_i;
                     end else if (w_accept) begin
                        r_skidData <= in_data_i;
                        r_skidExc  <= in_exc_i;
                     end else if (w_consume) begin
                        r_mainData <= '0;
                        r_mainExc  <= '0;
                     end
                  end
                  OCC_FULL: begin
                     if (w_consume) begin
                        r_mainData <= r_skidData;
                        r_mainExc  <= r_skidExc;
                        r_skidData <= '0;
                        r_skidExc  <= '0;
                     end
                  end
                  default: ;
               endcase
            end
         end

         assign in_ready_o = r_inReady;
      end else begin : g_single
         always_ff @(posedge clk) begin
            if (rst || clear_i) begin
               r_mainData <= '0;
               r_mainExc  <= '0;
               r_outValid <= 1'b0;
               r_occ      <= OCC_EMPTY;
            end else if (w_accept) begin
               r_mainData <= in_data_i;
               r_mainExc  <= in_exc_i;
               r_outValid <= 1'b1;
               r_occ      <= OCC_ONE;
            end else if (w_consume) begin
               r_mainData <= '0;
               r_mainExc  <= '0;
               r_outValid <= 1'b0;
               r_occ      <= OCC_EMPTY;
            end
         end

         assign in_ready_o = ~r_outValid | (out_ready_i & ~stall_i);
      end
   endgenerate

   assign w_stallEn = r_outValid & (~out_ready_i | stall_i);

   morty_sat_counter #(
      .WIDTH (CNT_W)
   ) u_stallCnt (
      .clk   (clk),
      .rst   (rst),
      .en_i  (w_stallEn),
      .cnt_o (stall_cnt_o)
   );

   assign out_valid_o = r_outValid;
   assign out_data_o  = r_mainData;
   assign out_exc_o   = r_mainExc;
   assign occ_o       = r_occ;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Three stage instances (skid, single, skid with 4-bit counter) share stimulus;
// each has its own queue scoreboard and stall-count model.
module tb_pipe_stage_buf;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        stall = 1'b0;
   logic        inValid = 1'b0;
   logic [31:0] inData = '0;
   logic [10:0] inExc = '0;
   logic        outReady = 1'b0;

   logic        rdyA, rdyB, rdyC;
   logic        valA, valB, valC;
   logic [31:0] datA, datB, datC;
   logic [10:0] excA, excB, excC;
   logic [1:0]  occA, occB, occC;
   logic [15:0] cntA, cntB;
   logic [3:0]  cntC;

   int checks = 0;
   int errors = 0;

   logic [42:0] sbQ [3][$];
   int          expCnt [3];
   bit          armed [3];

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(32), .EXC_W(11), .SKID(1), .CNT_W(16)) dutSkid (
      .clk(clk), .rst(rst), .clear_i(clear), .stall_i(stall),
      .in_valid_i(inValid), .in_ready_o(rdyA), .in_data_i(inData), .in_exc_i(inExc),
      .out_valid_o(valA), .out_ready_i(outReady), .out_data_o(datA), .out_exc_o(excA),
      .occ_o(occA), .stall_cnt_o(cntA));

   pipe_stage_buf #(.DATA_W(32), .EXC_W(11), .SKID(0), .CNT_W(16)) dutSingle (
      .clk(clk), .rst(rst), .clear_i(clear), .stall_i(stall),
      .in_valid_i(inValid), .in_ready_o(rdyB), .in_data_i(inData), .in_exc_i(inExc),
      .out_valid_o(valB), .out_ready_i(outReady), .out_data_o(datB), .out_exc_o(excB),
      .occ_o(occB), .stall_cnt_o(cntB));

   pipe_stage_buf #(.DATA_W(32), .EXC_W(11), .SKID(1), .CNT_W(4)) dutNarrow (
      .clk(clk), .rst(rst), .clear_i(clear), .stall_i(stall),
      .in_valid_i(inValid), .in_ready_o(rdyC), .in_data_i(inData), .in_exc_i(inExc),
      .out_valid_o(valC), .out_ready_i(outReady), .out_data_o(datC), .out_exc_o(excC),
      .occ_o(occC), .stall_cnt_o(cntC));

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [10:0] e,
                                input logic rdy, input logic stl, input logic clr, input logic rs);
      inValid  = v;
      inData   = d;
      inExc    = e;
      outReady = rdy;
      stall    = stl;
      clear    = clr;
      rst      = rs;
      @(posedge clk);
      #1;
   endtask

   // Compare one instance against its model, then advance the model by this cycle's handshakes.
   task automatic modelStep(input int k, input string name, input logic dutReady, input logic dutValid,
                            input logic [1:0] dutOcc, input logic [31:0] dutData, input logic [10:0] dutExc,
                            input logic [15:0] dutCnt, input bit isSkid, input int cntMax);
      logic [42:0] front;
      bit          expValid, expReady, cons, acc;
      int          size;
      if (rst) begin
         sbQ[k].delete();
         expCnt[k] = 0;
         armed[k]  = 1'b1;
         return;
      end
      if (!armed[k]) return;
      size     = sbQ[k].size();
      expValid = (size != 0);
      front    = expValid ? sbQ[k][0] : 43'd0;
      expReady = isSkid ? (size != 2) : (!expValid || (outReady && !stall));
      checkOutput({name, ".valid"}, {63'd0, dutValid}, {63'd0, expValid});
      checkOutput({name, ".occ"}, {62'd0, dutOcc}, 64'(size));
      checkOutput({name, ".data"}, {32'd0, dutData}, {32'd0, front[31:0]});
      checkOutput({name, ".exc"}, {53'd0, dutExc}, {53'd0, front[42:32]});
      checkOutput({name, ".ready"}, {63'd0, dutReady}, {63'd0, expReady});
      checkOutput({name, ".stallCnt"}, {48'd0, dutCnt}, 64'(expCnt[k]));
      cons = expValid && outReady && !stall;
      acc  = inValid && expReady && !clear;
      if (clear) begin
         sbQ[k].delete();
      end else begin
         if (cons) void'(sbQ[k].pop_front());
         if (acc) sbQ[k].push_back({inExc, inData});
      end
      if (expValid && (!outReady || stall) && (expCnt[k] < cntMax)) expCnt[k]++;
   endtask

   always @(negedge clk) begin
      modelStep(0, "skid", rdyA, valA, occA, datA, excA, cntA, 1'b1, 65535);
      modelStep(1, "single", rdyB, valB, occB, datB, excB, cntB, 1'b0, 65535);
      modelStep(2, "narrow", rdyC, valC, occC, datC, excC, {12'd0, cntC}, 1'b1, 15);
   end

   initial begin
      logic [15:0] savedCnt;

      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      checkOutput("reset.ready", {63'd0, rdyA}, 64'd1);
      checkOutput("reset.occ", {62'd0, occA}, 64'd0);

      // Single item through an empty stage shows up one cycle later.
      applyStimulus(1, 32'hDEADBEEF, 11'h004, 1, 0, 0, 0);
      checkOutput("first.valid", {63'd0, valA}, 64'd1);
      checkOutput("first.data", {32'd0, datA}, 64'hDEADBEEF);
      checkOutput("first.exc", {53'd0, excA}, 64'h004);
      checkOutput("first.occ", {62'd0, occA}, 64'd1);
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 0, 0);

      // Fill skid entry while downstream is blocked, then drain.
      applyStimulus(1, 32'hA1, 11'h1, 0, 0, 0, 0);
      applyStimulus(1, 32'hA2, 11'h2, 0, 0, 0, 0);
      checkOutput("fill.occ", {62'd0, occA}, 64'd2);
      checkOutput("fill.ready", {63'd0, rdyA}, 64'd0);
      checkOutput("fill.head", {32'd0, datA}, 64'hA1);
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("drain.second", {32'd0, datA}, 64'hA2);
      checkOutput("drain.ready", {63'd0, rdyA}, 64'd1);
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("drain.empty", {62'd0, occA}, 64'd0);

      // Flush a full stage while an item is offered.
      applyStimulus(1, 32'hB1, 11'h3, 0, 0, 0, 0);
      applyStimulus(1, 32'hB2, 11'h4, 0, 0, 0, 0);
      savedCnt = cntA;
      applyStimulus(1, 32'h55, 11'h5, 1, 0, 1, 0);
      checkOutput("clear.occ", {62'd0, occA}, 64'd0);
      checkOutput("clear.valid", {63'd0, valA}, 64'd0);
      checkOutput("clear.data", {32'd0, datA}, 64'd0);
      checkOutput("clear.stallCnt", {48'd0, cntA}, {48'd0, savedCnt});
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("clear.stillEmpty", {63'd0, valA}, 64'd0);

      // Stall with ready high holds the output and counts every cycle.
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      applyStimulus(1, 32'hC3, 11'h6, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 1, 0, 0);
      checkOutput("stall.held", {32'd0, datA}, 64'hC3);
      checkOutput("stall.cnt5", {48'd0, cntA}, 64'd5);
      for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 1, 1, 0, 0);
      checkOutput("stall.cnt20", {48'd0, cntA}, 64'd20);
      checkOutput("stall.narrowSat", {60'd0, cntC}, 64'd15);
      applyStimulus(0, 0, 0, 1, 0, 0, 0);

      // Reset while full discards everything.
      applyStimulus(1, 32'hD1, 11'h7, 0, 0, 0, 0);
      applyStimulus(1, 32'hD2, 11'h8, 0, 0, 0, 0);
      checkOutput("preReset.occ", {62'd0, occA}, 64'd2);
      applyStimulus(1, 32'hD3, 11'h9, 1, 1, 1, 1);
      checkOutput("midReset.occ", {62'd0, occA}, 64'd0);
      checkOutput("midReset.valid", {63'd0, valA}, 64'd0);
      checkOutput("midReset.data", {32'd0, datA}, 64'd0);
      checkOutput("midReset.exc", {53'd0, excA}, 64'd0);
      checkOutput("midReset.ready", {63'd0, rdyA}, 64'd1);
      checkOutput("midReset.stallCnt", {48'd0, cntA}, 64'd0);

      for (int i = 0; i < 10000; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom, 11'($urandom_range(0, 2047)),
                       $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0, 0, 0);
         checkOutput("random.singleOcc", {63'd0, (occB > 2'd1)}, 64'd0);
      end
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("final.skidEmpty", {62'd0, occA}, 64'd0);
      checkOutput("final.singleEmpty", {62'd0, occB}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
